// File: rtl/hazard_scheduler_pkg.sv
// Shared types and constants for the pipeline hazard scheduler: forwarding select
// encodings, MDU sequencer states and register-match helpers.
package hazard_scheduler_pkg;

  localparam int REG_SIZE = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_BUSY = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_e;

  // True when a writer targets src; register 0 is hard-wired and never matches.
  function automatic logic reg_hit(input logic [REG_SIZE-1:0] src,
                                   input logic                we,
                                   input logic [REG_SIZE-1:0] wr);
    return we && (wr != {REG_SIZE{1'b0}}) && (wr == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_SIZE-1:0] src,
                                         input logic                we_m,
                                         input logic [REG_SIZE-1:0] wr_m,
                                         input logic                we_w,
                                         input logic [REG_SIZE-1:0] wr_w);
    logic [1:0] sel;
    if (reg_hit(src, we_m, wr_m)) begin
      sel = FWD_MEM;
    end else if (reg_hit(src, we_w, wr_w)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Pipeline-to-hazard-unit bundle: stage register ids and control bits in,
// forwarding selects, stall/flush controls and MDU status out.
interface hazard_scheduler_if;
  import hazard_scheduler_pkg::*;

  logic [REG_SIZE-1:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic                branchD, Regfile_weE, memToRegE, Regfile_weM, memToRegM;
  logic                Regfile_weW, mduStartE, mduIsDivE;
  logic                forwardAD, forwardBD;
  logic [1:0]          forwardAE, forwardBE;
  logic                stallF, stallD, stallE, flushE, flushM, mduBusy, mduDoneE;

  modport master (
    output rsD, rtD, branchD, rsE, rtE, writeRegE, Regfile_weE, memToRegE,
           writeRegM, Regfile_weM, memToRegM, writeRegW, Regfile_weW,
           mduStartE, mduIsDivE,
    input  forwardAD, forwardBD, forwardAE, forwardBE, stallF, stallD, stallE,
           flushE, flushM, mduBusy, mduDoneE
  );

  modport slave (
    input  rsD, rtD, branchD, rsE, rtE, writeRegE, Regfile_weE, memToRegE,
           writeRegM, Regfile_weM, memToRegM, writeRegW, Regfile_weW,
           mduStartE, mduIsDivE,
    output forwardAD, forwardBD, forwardAE, forwardBE, stallF, stallD, stallE,
           flushE, flushM, mduBusy, mduDoneE
  );
endinterface

// File: rtl/hazard_scheduler_mdu_seq.sv
// Multiply/divide sequencer: IDLE -> BUSY -> DONE. busy covers the whole freeze
// (including the start cycle in IDLE); done marks the single result cycle.
module mdu_seq
  import hazard_scheduler_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic isDiv,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] load_s;

  // cnt holds the BUSY cycles still to go, so residency = start cycle + load + DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    load_s  = isDiv ? DIV_LOAD : MUL_LOAD;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          busy = 1'b1;
          if (load_s == CNT_ZERO) begin
            state_d = MDU_DONE;
          end else begin
            state_d = MDU_BUSY;
            cnt_d   = load_s;
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      MDU_BUSY: begin
        busy = 1'b1;
        if (cnt_q <= CNT_ONE) begin
          state_d = MDU_DONE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      MDU_DONE: begin
        done    = 1'b1;
        state_d = MDU_IDLE;
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: combinational forwarding and load-use/branch stalls,
// overridden by a full F/D/E freeze with M bubbling while the MDU runs.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scheduler_if.slave  hz
);

  logic mdu_busy_s, mdu_done_s, lw_stall_s, br_stall_s, hz_stall_s;

  mdu_seq #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_mdu_seq (
    .clk  (clk),
    .rst  (rst),
    .start(hz.mduStartE),
    .isDiv(hz.mduIsDivE),
    .busy (mdu_busy_s),
    .done (mdu_done_s)
  );

  // Data hazards that need a D-stage hold.
  always_comb begin
    lw_stall_s = reg_hit(hz.rsD, hz.memToRegE, hz.writeRegE) ||
                 reg_hit(hz.rtD, hz.memToRegE, hz.writeRegE);
    br_stall_s = hz.branchD &&
                 (reg_hit(hz.rsD, hz.Regfile_weE, hz.writeRegE) ||
                  reg_hit(hz.rtD, hz.Regfile_weE, hz.writeRegE) ||
                  reg_hit(hz.rsD, hz.memToRegM, hz.writeRegM) ||
                  reg_hit(hz.rtD, hz.memToRegM, hz.writeRegM));
    hz_stall_s = lw_stall_s || br_stall_s;
  end

  // Output selection; MDU freeze takes priority and masks ordinary hazard stalls.
  always_comb begin
    hz.forwardAD = 1'b0;
    hz.forwardBD = 1'b0;
    hz.forwardAE = FWD_REG;
    hz.forwardBE = FWD_REG;
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.flushE    = 1'b0;
    hz.flushM    = 1'b0;
    hz.mduBusy   = 1'b0;
    hz.mduDoneE  = 1'b0;
    if (rst) begin
      hz.mduBusy  = 1'b0;
      hz.mduDoneE = 1'b0;
    end else begin
      hz.forwardAD = reg_hit(hz.rsD, hz.Regfile_weM, hz.writeRegM);
      hz.forwardBD = reg_hit(hz.rtD, hz.Regfile_weM, hz.writeRegM);
      hz.forwardAE = fwd_sel(hz.rsE, hz.Regfile_weM, hz.writeRegM,
                             hz.Regfile_weW, hz.writeRegW);
      hz.forwardBE = fwd_sel(hz.rtE, hz.Regfile_weM, hz.writeRegM,
                             hz.Regfile_weW, hz.writeRegW);
      if (mdu_busy_s) begin
        hz.stallF  = 1'b1;
        hz.stallD  = 1'b1;
        hz.stallE  = 1'b1;
        hz.flushM  = 1'b1;
        hz.mduBusy = 1'b1;
      end else begin
        hz.stallF   = hz_stall_s;
        hz.stallD   = hz_stall_s;
        hz.flushE   = hz_stall_s;
        hz.mduDoneE = mdu_done_s;
      end
    end
  end

endmodule
